// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared board geometry and reader state encoding for the life engine
package life_pkg;

  localparam int LIFE_ROWS = 16;
  localparam int LIFE_COLS = 16;

  typedef logic [LIFE_ROWS*LIFE_COLS-1:0] life_board_t;
  typedef logic [LIFE_COLS-1:0]           life_row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } reader_state_t;

endpackage

// File: rtl/life_frame_reader.sv
// rtl/life_frame_reader.sv - snapshots the engine board and streams it out one row per transfer
module life_frame_reader
  import life_pkg::*;
#(
  parameter int ROWS  = LIFE_ROWS,
  parameter int COLS  = LIFE_COLS,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] board,
  input  logic                 snap,
  output logic                 busy,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [COLS-1:0]      row_data,
  output logic [ROW_W-1:0]     row_idx,
  output logic                 row_last,
  output logic                 frame_done,
  output logic                 snap_dropped
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [1:0]           state;
  logic [ROWS*COLS-1:0] shadow;

  // The shadow copy lets the engine keep evolving while the frame drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      shadow       <= '0;
      row_idx      <= '0;
      snap_dropped <= 1'b0;
    end else begin
      snap_dropped <= snap && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (snap) begin
            shadow  <= board;
            row_idx <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (row_ready) begin
            if (row_idx == LAST_ROW) state <= S_DONE;
            else                     row_idx <= row_idx + 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          row_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  always_comb begin
    busy       = (state == S_SEND) || (state == S_DONE);
    row_valid  = (state == S_SEND);
    frame_done = (state == S_DONE);
    row_last   = row_valid && (row_idx == LAST_ROW);
    row_data   = shadow[row_idx*COLS +: COLS];
  end

endmodule

// File: tb/tb_life_frame_reader.sv
// tb/tb_life_frame_reader.sv - directed scoreboard bench for life_frame_reader
module tb_life_frame_reader;
  import life_pkg::*;

  localparam int ROWS = LIFE_ROWS;
  localparam int COLS = LIFE_COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  life_board_t board = '0;
  logic        snap = 1'b0;
  logic        row_ready = 1'b0;
  logic        busy, row_valid, row_last, frame_done, snap_dropped;
  life_row_t   row_data;
  logic [3:0]  row_idx;

  life_frame_reader #(.ROWS(ROWS), .COLS(COLS), .ROW_W(4)) dut (
    .clk(clk), .reset(reset), .board(board), .snap(snap), .busy(busy),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .frame_done(frame_done),
    .snap_dropped(snap_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    life_row_t  data;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0, fd_cnt = 0, sd_cnt = 0, xfer_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input life_board_t b);
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      e.data = b[r*COLS +: COLS];
      e.idx  = 4'(r);
      e.last = (r == ROWS - 1);
      sbq.push_back(e);
    end
  endtask

  // Pops the scoreboard for a transfer about to happen at the coming edge.
  task automatic tick();
    if (row_valid && row_ready) begin
      xfer_cnt++;
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        exp_t e = sbq.pop_front();
        chk("row_data", 32'(row_data), 32'(e.data));
        chk("row_idx", 32'(row_idx), 32'(e.idx));
        chk("row_last", 32'(row_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (snap_dropped) sd_cnt++;
  endtask

  task automatic drain(input string tag);
    bit seen = 1'b0;
    row_ready = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    tick();
  endtask

  task automatic rand_board(output life_board_t b);
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    life_board_t b;
    logic        pv, prdy;
    life_row_t   pd;
    logic [3:0]  px;
    bit          hit;
    int          fd0;

    // Reset and async-reset-mid-frame clearing
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    board = '0;
    board[15:0] = 16'hABCD;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("rst_pre_valid", 32'(row_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(row_valid), 32'd0);
    chk("rst_data", 32'(row_data), 32'd0);
    chk("rst_idx", 32'(row_idx), 32'd0);
    chk("rst_last", 32'(row_last), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(snap_dropped), 32'd0);
    sbq.delete();
    @(negedge clk) reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(row_valid), 32'd0);

    // Basic frame
    board = 256'h7;
    row_ready = 1'b1;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("basic_valid", 32'(row_valid), 32'd1);
    chk("basic_idx0", 32'(row_idx), 32'd0);
    chk("basic_row0", 32'(row_data), 32'h7);
    chk("basic_busy", 32'(busy), 32'd1);
    fd_cnt = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("basic_last15", 32'(row_last), 32'd1);
    chk("basic_no_early_done", 32'(fd_cnt), 32'd0);
    tick();
    chk("basic_done", 32'(frame_done), 32'd1);
    chk("basic_done_valid", 32'(row_valid), 32'd0);
    tick();
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_done", 32'(frame_done), 32'd0);
    chk("basic_sb_empty", 32'(sbq.size()), 32'd0);

    // Backpressure with ready pattern 1,0,0,...
    for (int r = 0; r < ROWS; r++) board[r*COLS +: COLS] = 16'(1 << r);
    row_ready = 1'b0;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    fd_cnt = 0;
    xfer_cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      row_ready = (i % 3 == 0);
      pv = row_valid; prdy = row_ready; pd = row_data; px = row_idx;
      tick();
      if (frame_done) hit = 1'b1;
      else if (pv && !prdy) begin
        chk("bp_hold_data", 32'(row_data), 32'(pd));
        chk("bp_hold_idx", 32'(row_idx), 32'(px));
      end
    end
    chk("bp_done_seen", 32'(hit), 32'd1);
    chk("bp_xfers_at_done", 32'(xfer_cnt), 32'd16);
    chk("bp_done_count", 32'(fd_cnt), 32'd1);
    chk("bp_sb_empty", 32'(sbq.size()), 32'd0);
    tick();

    // Shadow isolation
    board = 256'h3;
    row_ready = 1'b0;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    board = 256'h7;
    tick();
    tick();
    chk("shadow_row0", 32'(row_data), 32'h3);
    chk("shadow_idx", 32'(row_idx), 32'd0);
    drain("shadow");

    // Dropped snaps in SEND and DONE
    rand_board(b);
    board = b;
    row_ready = 1'b1;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    sd_cnt = 0;
    for (int i = 0; i < 40 && !(row_valid && row_idx == 4'd5); i++) tick();
    chk("drop_at_row5", 32'(row_idx), 32'd5);
    board = ~b;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("drop_send_pulse", 32'(snap_dropped), 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (frame_done) hit = 1'b1;
    end
    chk("drop_frame_done", 32'(hit), 32'd1);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("drop_done_pulse", 32'(snap_dropped), 32'd1);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    chk("drop_count", 32'(sd_cnt), 32'd2);
    chk("drop_sb_empty", 32'(sbq.size()), 32'd0);
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("after_drop_valid", 32'(row_valid), 32'd1);
    chk("after_drop_idx", 32'(row_idx), 32'd0);
    chk("after_drop_nodrop", 32'(snap_dropped), 32'd0);
    drain("after_drop");

    // Abort mid-frame at row 8
    rand_board(b);
    board = b;
    row_ready = 1'b1;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 40 && !(row_valid && row_idx == 4'd8); i++) tick();
    chk("abort_at_row8", 32'(row_idx), 32'd8);
    row_ready = 1'b0;
    fd0 = fd_cnt;
    #3 reset = 1'b1;
    #1;
    chk("abort_valid", 32'(row_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_idx", 32'(row_idx), 32'd0);
    sbq.delete();
    @(negedge clk) reset = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(fd_cnt), 32'(fd0));
    rand_board(b);
    board = b;
    push_frame(board);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("restart_idx", 32'(row_idx), 32'd0);
    chk("restart_row0", 32'(row_data), 32'(b[15:0]));
    drain("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
